// File: rtl/syscall_console_tx_pkg.sv
// Shared definitions for the console-side syscall responder: syscall codes,
// ASCII constants, the FSM state type and the power-of-ten lookup.
package syscall_console_tx_pkg;

  localparam logic [31:0] SYS_PRINT_INT    = 32'd1;
  localparam logic [31:0] SYS_PRINT_STRING = 32'd4;
  localparam logic [31:0] SYS_PRINT_CHAR   = 32'd11;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    EMIT,
    INT_SIGN,
    INT_DIGIT,
    INT_EMIT,
    DONE
  } txState_e;

  // Power-of-ten ROM used by the decimal digit generator (index 9 = 10^9).
  function automatic logic [31:0] pow10(input logic [3:0] idx);
    case (idx)
      4'd0:    return 32'd1;
      4'd1:    return 32'd10;
      4'd2:    return 32'd100;
      4'd3:    return 32'd1000;
      4'd4:    return 32'd10000;
      4'd5:    return 32'd100000;
      4'd6:    return 32'd1000000;
      4'd7:    return 32'd10000000;
      4'd8:    return 32'd100000000;
      4'd9:    return 32'd1000000000;
      default: return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/syscall_console_tx_if.sv
// Bundle of the request, memory-read and character-stream signals of the
// console responder. The slave view belongs to the responder, the master
// view to whatever drives requests, serves memory and sinks characters.
interface syscall_console_tx_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_v0;
  logic [31:0]       req_a0;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd_data;

  logic              ch_valid;
  logic              ch_ready;
  logic [7:0]        ch_data;

  logic              busy;
  logic              done;
  logic              trunc;

  modport slave (
    input  req_valid, req_v0, req_a0, mem_rd_data, ch_ready,
    output req_ready, mem_rd_en, mem_addr, ch_valid, ch_data, busy, done, trunc
  );

  modport master (
    output req_valid, req_v0, req_a0, mem_rd_data, ch_ready,
    input  req_ready, mem_rd_en, mem_addr, ch_valid, ch_data, busy, done, trunc
  );

endinterface

// File: rtl/syscall_console_tx_dec_digit_gen.sv
// Decimal digit generator: converts an unsigned 32-bit magnitude to digits
// from 10^9 down to 10^0 with one compare/subtract per cycle. A digit is
// ready when the remainder drops below the current power; next_digit moves
// to the following power.
module dec_digit_gen
  import syscall_console_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] value,
  input  logic        next_digit,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        last
);

  logic [31:0] remainder;
  logic [3:0]  index;
  logic [3:0]  subCount;
  logic        running;
  logic [31:0] power;

  assign power       = pow10(index);
  assign digit_valid = running && (remainder < power);
  assign digit       = subCount;
  assign last        = (index == 4'd0);

  // Load on start, otherwise subtract the current power until the digit settles,
  // and step down one power whenever the consumer takes the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      remainder <= '0;
      index     <= '0;
      subCount  <= '0;
      running   <= 1'b0;
    end else if (start) begin
      remainder <= value;
      index     <= 4'd9;
      subCount  <= '0;
      running   <= 1'b1;
    end else if (running) begin
      if (next_digit) begin
        subCount <= '0;
        if (index == 4'd0) running <= 1'b0;
        else               index   <= index - 4'd1;
      end else if (!digit_valid) begin
        remainder <= remainder - power;
        subCount  <= subCount + 4'd1;
      end
    end
  end

endmodule

// File: rtl/syscall_console_tx.sv
// Console-side responder for syscall print requests. Accepts one request,
// fetches string bytes from data memory when needed, converts integers to
// decimal, and streams ASCII characters over a valid/ready byte port.
module syscall_console_tx
  import syscall_console_tx_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int ADDR_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  syscall_console_tx_if.slave  bus
);

  localparam int CNT_W = $clog2(MAX_LEN + 1);

  txState_e          state;
  logic              isChar;
  logic              seenDigit;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       word;
  logic              chValid;
  logic [7:0]        chData;
  logic              doneReg;
  logic              truncReg;

  logic [31:0]       magnitude;
  logic [ADDR_W-1:0] ptrNext;
  logic [CNT_W-1:0]  countNext;
  logic [7:0]        nextByte;
  logic [7:0]        fetchedByte;
  logic              handshake;
  logic              digitStart;
  logic              digitNext;
  logic              suppress;
  logic [3:0]        digit;
  logic              digitValid;
  logic              digitLast;

  assign magnitude   = bus.req_a0[31] ? ((~bus.req_a0) + 32'd1) : bus.req_a0;
  assign ptrNext     = ptr + ADDR_W'(1);
  assign countNext   = (count == CNT_W'(MAX_LEN)) ? count : count + CNT_W'(1);
  assign nextByte    = word[{ptrNext[1:0], 3'b000} +: 8];
  assign fetchedByte = bus.mem_rd_data[{ptr[1:0], 3'b000} +: 8];
  assign handshake   = chValid && bus.ch_ready;
  assign suppress    = (digit == 4'd0) && !seenDigit && !digitLast;
  assign digitStart  = (state == IDLE) && bus.req_valid && (bus.req_v0 == SYS_PRINT_INT);
  assign digitNext   = ((state == INT_DIGIT) && digitValid && suppress) ||
                       ((state == INT_EMIT) && handshake && !digitLast);

  dec_digit_gen digitGen (
    .clk         (clk),
    .rst         (rst),
    .start       (digitStart),
    .value       (magnitude),
    .next_digit  (digitNext),
    .digit       (digit),
    .digit_valid (digitValid),
    .last        (digitLast)
  );

  // Request FSM: owns the pointer, count and word registers and the character stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      isChar    <= 1'b0;
      seenDigit <= 1'b0;
      ptr       <= '0;
      count     <= '0;
      word      <= '0;
      chValid   <= 1'b0;
      chData    <= '0;
      doneReg   <= 1'b0;
      truncReg  <= 1'b0;
    end else begin
      doneReg  <= 1'b0;
      truncReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            isChar    <= 1'b0;
            seenDigit <= 1'b0;
            case (bus.req_v0)
              SYS_PRINT_CHAR: begin
                isChar  <= 1'b1;
                chValid <= 1'b1;
                chData  <= bus.req_a0[7:0];
                state   <= EMIT;
              end
              SYS_PRINT_STRING: begin
                ptr   <= ADDR_W'(bus.req_a0);
                count <= '0;
                state <= FETCH;
              end
              SYS_PRINT_INT: begin
                if (bus.req_a0[31]) begin
                  chValid <= 1'b1;
                  chData  <= ASCII_MINUS;
                  state   <= INT_SIGN;
                end else begin
                  state <= INT_DIGIT;
                end
              end
              default: begin
                doneReg <= 1'b1;
                state   <= DONE;
              end
            endcase
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          word <= bus.mem_rd_data;
          if (fetchedByte == 8'h00) begin
            doneReg <= 1'b1;
            state   <= DONE;
          end else begin
            chValid <= 1'b1;
            chData  <= fetchedByte;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (handshake) begin
            if (isChar) begin
              chValid <= 1'b0;
              doneReg <= 1'b1;
              state   <= DONE;
            end else begin
              ptr   <= ptrNext;
              count <= countNext;
              if (countNext == CNT_W'(MAX_LEN)) begin
                chValid  <= 1'b0;
                doneReg  <= 1'b1;
                truncReg <= 1'b1;
                state    <= DONE;
              end else if (ptrNext[1:0] == 2'b00) begin
                chValid <= 1'b0;
                state   <= FETCH;
              end else if (nextByte == 8'h00) begin
                chValid <= 1'b0;
                doneReg <= 1'b1;
                state   <= DONE;
              end else begin
                chData <= nextByte;
              end
            end
          end
        end
        INT_SIGN: begin
          if (handshake) begin
            chValid <= 1'b0;
            state   <= INT_DIGIT;
          end
        end
        INT_DIGIT: begin
          if (digitValid && !suppress) begin
            chValid   <= 1'b1;
            chData    <= ASCII_ZERO + {4'b0000, digit};
            seenDigit <= 1'b1;
            state     <= INT_EMIT;
          end
        end
        INT_EMIT: begin
          if (handshake) begin
            chValid <= 1'b0;
            if (digitLast) begin
              doneReg <= 1'b1;
              state   <= DONE;
            end else begin
              state <= INT_DIGIT;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.mem_rd_en = (state == FETCH);
  assign bus.mem_addr  = {ptr[ADDR_W-1:2], 2'b00};
  assign bus.ch_valid  = chValid;
  assign bus.ch_data   = chData;
  assign bus.done      = doneReg;
  assign bus.trunc     = truncReg;

endmodule

// File: tb/tb_syscall_console_tx.sv
// Bench for the console responder. Two instances (long and short MAX_LEN)
// receive the same requests; their character streams, read counts and
// done/trunc pulses are compared with a behavioural model of the syscalls.
module tb_syscall_console_tx;

  localparam int NDUT = 2;
  localparam int LEN0 = 1024;
  localparam int LEN1 = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic [31:0] reqV0 = '0;
  logic [31:0] reqA0 = '0;
  logic        chReady = 1'b1;
  int          readyMode = 0;

  logic        reqReadyW [NDUT];
  logic        chValidW  [NDUT];
  logic        memRdEnW  [NDUT];
  logic        busyW     [NDUT];
  logic        doneW     [NDUT];
  logic        truncW    [NDUT];
  logic [7:0]  chDataW   [NDUT];
  logic [31:0] memAddrW  [NDUT];

  int readCnt  [NDUT];
  int doneCnt  [NDUT];
  int truncCnt [NDUT];
  logic [7:0] gotQ0[$];
  logic [7:0] gotQ1[$];

  logic [31:0] memW [logic [31:0]];

  logic [7:0] expQ[$];
  int         expReads;
  int         expTrunc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    if (memW.exists(a)) return memW[a];
    return 32'h2E2E2E2E;
  endfunction

  function automatic logic [7:0] memByte(input logic [31:0] addr);
    logic [31:0] w;
    w = memWord(addr);
    return w[{addr[1:0], 3'b000} +: 8];
  endfunction

  task automatic putByte(input logic [31:0] addr, input logic [7:0] b);
    logic [31:0] w;
    w = memWord(addr);
    w[{addr[1:0], 3'b000} +: 8] = b;
    memW[{addr[31:2], 2'b00}] = w;
  endtask

  task automatic putString(input logic [31:0] addr, input string s);
    for (int i = 0; i < s.len(); i++) putByte(addr + 32'(i), s[i]);
    putByte(addr + 32'(s.len()), 8'h00);
  endtask

  // Reference behaviour: what the console must print for one request.
  task automatic modelRequest(input logic [31:0] v0, input logic [31:0] a0, input int maxLen);
    string       s;
    logic [31:0] addr;
    logic [7:0]  b;
    expQ.delete();
    expReads = 0;
    expTrunc = 0;
    if (v0 == 32'd11) begin
      expQ.push_back(a0[7:0]);
    end else if (v0 == 32'd1) begin
      s = $sformatf("%0d", $signed(a0));
      for (int i = 0; i < s.len(); i++) expQ.push_back(s[i]);
    end else if (v0 == 32'd4) begin
      addr = a0;
      while (1) begin
        if (expQ.size() == 0 || addr[1:0] == 2'b00) expReads++;
        b = memByte(addr);
        if (b == 8'h00) break;
        expQ.push_back(b);
        addr = addr + 32'd1;
        if (expQ.size() == maxLen) begin
          expTrunc = 1;
          break;
        end
      end
    end
  endtask

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    syscall_console_tx_if #(.ADDR_W(32)) bus ();
    logic [31:0] rdData;
    logic        stallPrev = 1'b0;
    logic [7:0]  heldData = 8'h00;
    logic        donePrev = 1'b0;

    assign bus.req_valid   = reqValid;
    assign bus.req_v0      = reqV0;
    assign bus.req_a0      = reqA0;
    assign bus.ch_ready    = chReady;
    assign bus.mem_rd_data = rdData;
    assign reqReadyW[g]    = bus.req_ready;
    assign chValidW[g]     = bus.ch_valid;
    assign memRdEnW[g]     = bus.mem_rd_en;
    assign busyW[g]        = bus.busy;
    assign doneW[g]        = bus.done;
    assign truncW[g]       = bus.trunc;
    assign chDataW[g]      = bus.ch_data;
    assign memAddrW[g]     = bus.mem_addr;

    syscall_console_tx #(.MAX_LEN((g == 0) ? LEN0 : LEN1), .ADDR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    // Memory answers one cycle after the strobe; garbage otherwise.
    always @(posedge clk) rdData <= bus.mem_rd_en ? memWord(bus.mem_addr) : 32'hDEADBEEF;

    // Stream monitor: captures transfers and checks hold-while-stalled and done/ready rules.
    always @(negedge clk) begin
      if (rst) begin
        stallPrev = 1'b0;
        donePrev  = 1'b0;
      end else begin
        if (stallPrev) begin
          checkOutput("holdValid", 64'(chValidW[g]), 64'd1);
          checkOutput("holdData", 64'(chDataW[g]), 64'(heldData));
        end
        if (donePrev) checkOutput("readyAfterDone", 64'(reqReadyW[g]), 64'd1);
        if (doneW[g]) begin
          doneCnt[g]++;
          checkOutput("readyInDone", 64'(reqReadyW[g]), 64'd0);
        end
        if (truncW[g]) begin
          truncCnt[g]++;
          checkOutput("truncWithDone", 64'(doneW[g]), 64'd1);
        end
        if (memRdEnW[g]) begin
          readCnt[g]++;
          checkOutput("addrAlign", 64'(memAddrW[g][1:0]), 64'd0);
        end
        if (chValidW[g] && chReady) begin
          if (g == 0) gotQ0.push_back(chDataW[g]);
          else        gotQ1.push_back(chDataW[g]);
        end
        stallPrev = chValidW[g] && !chReady;
        heldData  = chDataW[g];
        donePrev  = doneW[g];
      end
    end
  end

  // Console sink readiness: always, alternating, or random.
  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       chReady = 1'b1;
      1:       chReady = ~chReady;
      default: chReady = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic waitIdle(input string tag);
    int c;
    c = 0;
    while (c < 5000 && !(reqReadyW[0] && reqReadyW[1])) begin
      @(posedge clk); #2;
      c++;
    end
    if (c >= 5000) checkOutput({tag, ".timeout"}, 64'd0, 64'd1);
  endtask

  task automatic applyStimulus(input string name, input logic [31:0] v0, input logic [31:0] a0,
                               input int mode);
    int baseReads [NDUT];
    int baseDone  [NDUT];
    int baseTrunc [NDUT];
    logic [7:0] got[$];
    readyMode = mode;
    waitIdle({name, ".idle"});
    gotQ0.delete();
    gotQ1.delete();
    for (int d = 0; d < NDUT; d++) begin
      baseReads[d] = readCnt[d];
      baseDone[d]  = doneCnt[d];
      baseTrunc[d] = truncCnt[d];
    end
    reqValid = 1'b1;
    reqV0    = v0;
    reqA0    = a0;
    @(posedge clk); #2;
    reqValid = 1'b0;
    reqV0    = $urandom;
    reqA0    = $urandom;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput({name, ".busy"}, 64'(busyW[d]), 64'd1);
      if (v0 == 32'd11) begin
        checkOutput({name, ".charValidNext"}, 64'(chValidW[d]), 64'd1);
        checkOutput({name, ".charDataNext"}, 64'(chDataW[d]), 64'(a0[7:0]));
      end else if (v0 != 32'd1 && v0 != 32'd4) begin
        checkOutput({name, ".doneNext"}, 64'(doneW[d]), 64'd1);
      end
    end
    waitIdle({name, ".finish"});
    for (int d = 0; d < NDUT; d++) begin
      modelRequest(v0, a0, (d == 0) ? LEN0 : LEN1);
      if (d == 0) got = gotQ0;
      else        got = gotQ1;
      checkOutput({name, ".len"}, 64'(got.size()), 64'(expQ.size()));
      for (int i = 0; i < expQ.size() && i < got.size(); i++)
        checkOutput($sformatf("%s.dut%0d.char%0d", name, d, i), 64'(got[i]), 64'(expQ[i]));
      checkOutput({name, ".reads"}, 64'(readCnt[d] - baseReads[d]), 64'(expReads));
      checkOutput({name, ".done"}, 64'(doneCnt[d] - baseDone[d]), 64'd1);
      checkOutput({name, ".trunc"}, 64'(truncCnt[d] - baseTrunc[d]), 64'(expTrunc));
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          sel;
    int          mode;
    int          len;
    logic [31:0] v0;
    logic [31:0] a0;
    int          doneBase [NDUT];

    for (int d = 0; d < NDUT; d++) begin
      readCnt[d]  = 0;
      doneCnt[d]  = 0;
      truncCnt[d] = 0;
    end

    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput("rst.reqReady", 64'(reqReadyW[d]), 64'd1);
      checkOutput("rst.chValid", 64'(chValidW[d]), 64'd0);
      checkOutput("rst.memRdEn", 64'(memRdEnW[d]), 64'd0);
      checkOutput("rst.busy", 64'(busyW[d]), 64'd0);
      checkOutput("rst.done", 64'(doneW[d]), 64'd0);
      checkOutput("rst.trunc", 64'(truncW[d]), 64'd0);
      checkOutput("rst.chData", 64'(chDataW[d]), 64'd0);
      checkOutput("rst.memAddr", 64'(memAddrW[d]), 64'd0);
    end
    rst = 1'b0;

    applyStimulus("char", 32'd11, 32'h00000041, 0);

    memW[32'h7FF00000] = 32'h00216948;
    applyStimulus("strHi", 32'd4, 32'h7FF00000, 0);

    memW[32'h7FF00000] = 32'h62615A5A;
    memW[32'h7FF00004] = 32'h00006463;
    applyStimulus("strUnaligned", 32'd4, 32'h7FF00002, 2);

    applyStimulus("intNeg", 32'd1, 32'hFFFFFB4B, 0);
    applyStimulus("intZero", 32'd1, 32'h00000000, 1);
    applyStimulus("intMin", 32'd1, 32'h80000000, 2);
    applyStimulus("intMax", 32'd1, 32'h7FFFFFFF, 0);

    putString(32'h7FF00100, "ABCDEFGHIJ");
    applyStimulus("strStall", 32'd4, 32'h7FF00100, 1);

    putByte(32'hFFFFFFFE, 8'h78);
    putByte(32'hFFFFFFFF, 8'h79);
    putByte(32'h00000000, 8'h7A);
    putByte(32'h00000001, 8'h00);
    applyStimulus("strWrap", 32'd4, 32'hFFFFFFFE, 2);

    putString(32'h7FF00200, "");
    applyStimulus("strEmpty", 32'd4, 32'h7FF00200, 0);

    applyStimulus("code10", 32'd10, 32'h12345678, 0);
    applyStimulus("codeHigh", 32'h00010004, 32'h7FF00100, 0);

    // Reset in the middle of a string: no done, stream dropped, idle next cycle.
    putString(32'h7FF00300, "the quick brown fox jumps over the lazy dog");
    readyMode = 0;
    waitIdle("rstMid.idle");
    for (int d = 0; d < NDUT; d++) doneBase[d] = doneCnt[d];
    reqValid = 1'b1;
    reqV0    = 32'd4;
    reqA0    = 32'h7FF00300;
    @(posedge clk); #2;
    reqValid = 1'b0;
    repeat (3) begin
      @(posedge clk); #2;
    end
    for (int d = 0; d < NDUT; d++) checkOutput("rstMid.busyBefore", 64'(busyW[d]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput("rstMid.chValid", 64'(chValidW[d]), 64'd0);
      checkOutput("rstMid.reqReady", 64'(reqReadyW[d]), 64'd1);
      checkOutput("rstMid.done", 64'(doneW[d]), 64'd0);
    end
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #2;
    end
    for (int d = 0; d < NDUT; d++) begin
      checkOutput("rstMid.noDone", 64'(doneCnt[d] - doneBase[d]), 64'd0);
      checkOutput("rstMid.idle", 64'(reqReadyW[d]), 64'd1);
    end

    applyStimulus("afterRst", 32'd11, 32'h0000007E, 2);

    // Randomized mix of all request kinds and sink behaviours.
    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 9);
      mode = $urandom_range(0, 2);
      if (sel < 4) begin
        a0  = 32'h30000000 + (32'($urandom_range(0, 255)) << 4) + 32'($urandom_range(0, 3));
        len = $urandom_range(0, 12);
        for (int i = 0; i < len; i++) putByte(a0 + 32'(i), 8'($urandom_range(1, 255)));
        putByte(a0 + 32'(len), 8'h00);
        v0 = 32'd4;
      end else if (sel < 7) begin
        v0 = 32'd1;
        if ($urandom_range(0, 1) == 1) a0 = $urandom;
        else a0 = 32'(int'($urandom_range(0, 2000)) - 1000);
      end else if (sel < 9) begin
        v0 = 32'd11;
        a0 = $urandom;
      end else begin
        v0 = 32'($urandom_range(12, 40));
        a0 = $urandom;
      end
      applyStimulus($sformatf("rand%0d", n), v0, a0, mode);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
